// File: rtl/peripheral_div.sv
// Memory-mapped unsigned divider: A/B registers, INIT start, status and results.
// Sequential restoring divider resolving one quotient bit per clock.
module peripheral_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_in,
    input  logic             cs,
    input  logic [4:0]       addr,
    input  logic             rd,
    input  logic             wr,
    output logic [31:0]      d_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg, quot, rem;
    logic             done, busy, dz;
    logic [WIDTH-1:0] work_q, work_r, work_d;
    logic [CW-1:0]    cnt;

    logic             wr_en, rd_en, start;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] q_sh, r_nxt, q_nxt;
    logic [31:0]      rdata;

    assign wr_en = cs & wr;
    assign rd_en = cs & rd;
    assign start = wr_en && (addr == 5'h0C) && d_in[0];

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        r_sh  = {work_r, work_q[WIDTH-1]};
        q_sh  = {work_q[WIDTH-2:0], 1'b0};
        r_nxt = r_sh[WIDTH-1:0];
        q_nxt = q_sh;
        if (r_sh >= {1'b0, work_d}) begin
            r_nxt = WIDTH'(r_sh - {1'b0, work_d});
            q_nxt = q_sh | WIDTH'(1);
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            5'h04:   rdata = 32'(a_reg);
            5'h08:   rdata = 32'(b_reg);
            5'h10:   rdata = 32'(quot);
            5'h14:   rdata = 32'(rem);
            5'h18:   rdata = {29'b0, dz, busy, done};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_out <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (rd_en) d_out <= rdata;
            if (wr_en && addr == 5'h04) a_reg <= d_in;
            if (wr_en && addr == 5'h08) b_reg <= d_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            quot   <= '0;
            rem    <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            dz     <= 1'b0;
            work_q <= '0;
            work_r <= '0;
            work_d <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_reg != '0) begin
                            work_q <= a_reg;
                            work_d <= b_reg;
                            work_r <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            done   <= 1'b0;
                            dz     <= 1'b0;
                            state  <= RUN;
                        end else begin
                            quot <= '1;
                            rem  <= a_reg;
                            dz   <= 1'b1;
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    work_q <= q_nxt;
                    work_r <= r_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        quot  <= q_nxt;
                        rem   <= r_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_peripheral_div.sv
// Bus-level bench for peripheral_div: directed scenarios plus random operands
// checked against plain integer division.
module tb_peripheral_div;
    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] d_in;
    logic        cs, rd, wr;
    logic [4:0]  addr;
    logic [31:0] d_out;

    int n_tests = 0;
    int n_fail  = 0;

    peripheral_div #(.WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .d_in(d_in), .cs(cs),
        .addr(addr), .rd(rd), .wr(wr), .d_out(d_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_wr_cs(input logic c, input logic [4:0] a, input logic [15:0] d);
        cs = c; wr = 1'b1; addr = a; d_in = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd_cs(input logic c, input logic [4:0] a, output logic [31:0] v);
        cs = c; rd = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
        v = d_out;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [15:0] d);
        bus_wr_cs(1'b1, a, d);
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] v);
        bus_rd_cs(1'b1, a, v);
    endtask

    task automatic wait_done();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 40; i++) begin
            bus_rd(5'h18, v);
            if (v[0]) break;
        end
        chk("done_timeout", {31'b0, v[0]}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] v;
        logic [15:0] eq, er;
        eq = (b == 0) ? 16'hFFFF : a / b;
        er = (b == 0) ? a : a % b;
        bus_rd(5'h10, v); chk({tag, "_quot"}, v, {16'b0, eq});
        bus_rd(5'h14, v); chk({tag, "_rem"},  v, {16'b0, er});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [15:0] ra, rb;
        resetn = 1'b0; cs = 0; rd = 0; wr = 0; addr = '0; d_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", d_out, 32'd0);
        resetn = 1'b1;
        bus_rd(5'h18, v); chk("reset_status", v, 32'd0);
        bus_rd(5'h10, v); chk("reset_quot", v, 32'd0);
        bus_rd(5'h04, v); chk("reset_a", v, 32'd0);

        // 100/7 with exact busy window
        bus_wr(5'h04, 16'd100);
        bus_wr(5'h08, 16'd7);
        bus_wr(5'h0C, 16'd1);
        for (int i = 0; i < 16; i++) begin
            bus_rd(5'h18, v); chk($sformatf("busy_%0d", i), v, 32'h2);
        end
        bus_rd(5'h18, v); chk("done_status", v, 32'h1);
        check_result("d100_7", 16'd100, 16'd7);

        bus_wr(5'h04, 16'hFFFF); bus_wr(5'h08, 16'd1); bus_wr(5'h0C, 16'd1);
        wait_done(); check_result("dffff_1", 16'hFFFF, 16'd1);
        bus_wr(5'h04, 16'd5); bus_wr(5'h08, 16'd9); bus_wr(5'h0C, 16'd1);
        wait_done(); check_result("d5_9", 16'd5, 16'd9);

        // divide by zero: done right after the start edge
        bus_wr(5'h04, 16'd1234); bus_wr(5'h08, 16'd0); bus_wr(5'h0C, 16'd1);
        bus_rd(5'h18, v); chk("dz_status", v, 32'h5);
        check_result("dz", 16'd1234, 16'd0);
        bus_wr(5'h0C, 16'd0);
        bus_rd(5'h18, v); chk("init0_noop", v, 32'h5);

        // operand write and INIT while busy
        bus_wr(5'h04, 16'd100); bus_wr(5'h08, 16'd7); bus_wr(5'h0C, 16'd1);
        repeat (3) bus_rd(5'h18, v);
        bus_wr(5'h04, 16'd50);
        bus_wr(5'h0C, 16'd1);
        wait_done(); check_result("busy_ovl", 16'd100, 16'd7);
        bus_rd(5'h04, v); chk("a_rdback", v, 32'd50);
        bus_wr(5'h0C, 16'd1);
        bus_rd(5'h18, v); chk("restart_busy", v, 32'h2);
        wait_done(); check_result("d50_7", 16'd50, 16'd7);

        // reset mid-operation
        bus_wr(5'h04, 16'd100); bus_wr(5'h0C, 16'd1);
        repeat (7) begin @(posedge clk); #1; end
        resetn = 1'b0; #1;
        chk("rst_dout", d_out, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        bus_rd(5'h18, v); chk("rst_status", v, 32'd0);
        bus_rd(5'h10, v); chk("rst_quot", v, 32'd0);
        bus_rd(5'h14, v); chk("rst_rem", v, 32'd0);
        bus_wr(5'h04, 16'd9); bus_wr(5'h08, 16'd3); bus_wr(5'h0C, 16'd1);
        wait_done(); check_result("d9_3", 16'd9, 16'd3);

        // decode corners
        bus_rd(5'h1C, v); chk("unmapped", v, 32'd0);
        bus_rd(5'h10, v);
        bus_rd_cs(1'b0, 5'h18, v); chk("rd_nocs_hold", v, 32'd3);
        bus_wr_cs(1'b0, 5'h04, 16'd77);
        bus_rd(5'h04, v); chk("wr_nocs", v, 32'd9);

        // random operands
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            bus_wr(5'h04, ra); bus_wr(5'h08, rb); bus_wr(5'h0C, 16'd1);
            if (rb == 0) begin
                bus_rd(5'h18, v); chk("rnd_dz", v, 32'h5);
            end else begin
                wait_done();
                bus_rd(5'h18, v); chk("rnd_status", v, 32'h1);
            end
            check_result($sformatf("rnd%0d", i), ra, rb);
            bus_rd(5'h08, v); chk("rnd_b", v, {16'b0, rb});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/peripheral_div.md
# peripheral_div

Memory-mapped 16-bit unsigned integer divider on the SoC bus, selected by the address decoder's divider chip-select (`cs[2]`, region 0x0043xxxx). Its `d_out` feeds the top-level read-data mux. The CPU writes dividend and divisor, then starts the operation and polls status. It reads quotient and remainder once `done` is set. The datapath is a sequential restoring shift-subtract divider that resolves one quotient bit per clock.

## Interface
Parameters:
- `WIDTH`, 16: operand, quotient and remainder width; the register map below assumes 16.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `d_in`  in  16  write data, taken from `mem_wdata[15:0]`.
- `cs`  in  1  chip-select from the address decoder.
- `addr`  in  5  byte offset, taken from `mem_address[4:0]`.
- `rd`  in  1  read strobe (`mem_rstrb`).
- `wr`  in  1  write strobe (OR of `mem_wmask`).
- `d_out`  out  32  registered read data to the top-level mux.

## Operation
Register map (byte offsets; only accesses with `cs=1` take effect):
- 0x04 W `A`: dividend, 16 bits.
- 0x08 W `B`: divisor, 16 bits.
- 0x0C W `INIT`: writing `d_in[0]=1` starts a division; writing `d_in[0]=0` has no effect.
- 0x10 R: quotient, zero-extended.
- 0x14 R: remainder, zero-extended.
- 0x18 R: status; bit0 `done`, bit1 `busy`, bit2 `dz` (divide by zero); bits 31:3 are 0.
- 0x04 and 0x08 also read back `A` and `B`. Reads of any other offset return 0.

FSM states:
- IDLE:
  - On an `INIT` start with `B≠0`: latch `A` and `B` into working registers, clear the partial remainder, set the count to 0, set `busy=1`, `done=0`, `dz=0`, and go to RUN.
  - On an `INIT` start with `B=0`: set quotient = 0xFFFF, remainder = `A`, `dz=1`, `done=1`, `busy=0`; stay in IDLE.
- RUN: each edge performs one step:
  - Compute `{R,Q} <<= 1` with the next dividend bit shifted in.
  - If `R ≥ divisor`, then `R -= divisor` and set the quotient LSB to 1.
  - The partial remainder is 17 bits wide to hold the pre-subtract value.
  - After the 16th step, write the quotient and remainder result registers, set `done=1`, `busy=0`, and go to IDLE.
- Result registers and `done` hold until the next start. Any start clears `done` and `dz`.
- Writes to `A` or `B` while busy update those registers only. The running operation uses the operands latched at start.
- An `INIT` write while busy is ignored.
- Reads while busy return the previous result registers.

## Timing
- All outputs and registers reset to 0 asynchronously, including `d_out`, `A`, `B`, quotient, remainder, `done`, `busy`, `dz`, and the FSM (to IDLE). Reset mid-operation aborts the operation with no result update.
- Reset release is sampled synchronously by the FSM; the first start is accepted on the first edge after release.
- Writes are sampled on the edge where `cs & wr` is high.
- `d_out` loads the addressed value on the edge where `cs & rd` is high and holds otherwise. Read data is valid the cycle after the strobe, which matches the CPU read timing.
- Start sampled at edge N:
  - `busy` is visible after edge N.
  - RUN steps occur on edges N+1 through N+16.
  - `done=1` and the results are valid after edge N+16, a latency of 16 cycles.
- Divide by zero: `done` is valid after edge N (latency 0).
- `wr` and `rd` are never asserted together on a single access. If they are, the write is performed and `d_out` loads the pre-write value.

## Test plan
- `A=100`, `B=7`, start → `busy` for 16 cycles; then quotient = 14, remainder = 2, status = 0x1.
- `A=0xFFFF`, `B=1` → quotient = 0xFFFF, remainder = 0. `A=5`, `B=9` → quotient = 0, remainder = 5.
- `A=1234`, `B=0`, start → status = 0x5 on the next read; quotient = 0xFFFF, remainder = 1234.
- Start 100/7, write `A=50` and issue a second `INIT` at cycle 5 → result is still 14 r 2. Starting again afterwards uses `A=50` (50/7): `done` clears, then the result is 7 r 1.
- Assert `resetn=0` at cycle 8 of an operation → `d_out`, status and results are 0 immediately; `busy=0`. A new 9/3 after release gives 3 r 0.
- Read offset 0x1C, and read with `cs=0` → 0 and no `d_out` change, respectively. A write with `cs=0` leaves `A` unchanged.
